ntt_mlkem_masked_intt_bf_sched: RTL and testbench
=================================================

Name: ntt_mlkem_masked_intt_bf_sched

Overview:
- Sequences one ML-KEM INTT (Gentleman-Sande) layer through the masked GS butterfly, which has a fixed 15-clk latency and no stall input.
- Generates u/v read addresses and the zeta index for each butterfly, and gates issue on availability of fresh mask randomness.
- Tracks in-flight ops with a delay line and produces the u/v write-back addresses and write enable.
- Sits between the NTT top-level controller and the coefficient memory / masked butterfly datapath.

Parameters:
- ADDR_W, 8, coefficient address width (256 coefficients).
- RD_LAT, 1, clks from read address to operands at butterfly input.
- BF_LAT, 15, masked GS butterfly latency (u_o and v_o both valid BF_LAT clks after operands).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- zeroize  in  1  synchronous clear of all state
- start_i  in  1  start one layer pass; honoured only in IDLE
- layer_i  in  3  INTT layer L, 0..6; len = 2<<L
- rnd_valid_i  in  1  fresh 5x14b mask randomness is present this cycle
- busy_o  out  1  state != IDLE
- done_o  out  1  1-clk pulse at end of pass
- err_o  out  1  1-clk pulse when start_i arrives with layer_i > 6
- issue_o  out  1  butterfly op launched this cycle (read enable); also consumes randomness
- rd_u_addr_o  out  ADDR_W  u read address
- rd_v_addr_o  out  ADDR_W  v read address
- zeta_idx_o  out  7  twiddle ROM index
- wr_en_o  out  1  write-back strobe
- wr_u_addr_o  out  ADDR_W  u write address
- wr_v_addr_o  out  ADDR_W  v write address

Behaviour:
- Reset/zeroize: all outputs 0, state IDLE, counters and delay line cleared. An async reset or zeroize mid-pass aborts the pass: no further writes and no done_o.
- FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE, start_i=1, layer_i<=6: latch L, clear op counter i (7b), go to ISSUE.
- IDLE, start_i=1, layer_i>6: pulse err_o, stay IDLE.
- ISSUE: each cycle with rnd_valid_i=1, assert issue_o and increment i. With rnd_valid_i=0, issue_o=0 (a bubble) and i holds. After issuing i=127, go to DRAIN.
- Address generation for op i:
  - len = 2<<L, j = i & (len-1), g = i >> (L+1)
  - u = g*2*len + j, v = u + len
  - zeta = (128>>L) - 1 - g
  - Addresses are combinational from i, L; outputs are don't-care when issue_o=0.
- Delay line: {issue_o, u, v} delayed RD_LAT+BF_LAT = 16 clks, giving wr_en_o, wr_u_addr_o, wr_v_addr_o. Bubbles propagate as wr_en_o=0.
- DRAIN: count 16 clks after the last issue, then go to DONE.
- DONE: done_o=1 for one clk; this is the cycle after the last wr_en_o. Return to IDLE.
- start_i while busy_o=1 is ignored; L stays latched for the whole pass.
- Exactly 128 issue_o and 128 wr_en_o per pass, with wr_en_o(t) = issue_o(t-16).

Decomposition:
- Shared ntt_defines_pkg gains:
  - MLKEM_MASKED_GS_BF_LATENCY = 15
  - MLKEM_INTT_NUM_LAYERS = 7
  - state enum typedef ntt_bf_sched_state_e
- Sub-module ntt_mlkem_bf_wb_delay: parameterized-depth valid+address shift register with reset/zeroize clear. The scheduler instantiates it with depth RD_LAT+BF_LAT.

Test Plan:
- Layer 0, rnd_valid_i=1, start at t=0:
  - issue_o over t=1..128; op0 -> (0,2) zeta 127; op1 -> (1,3) zeta 127; op2 -> (4,6) zeta 126
  - wr_en_o over t=17..144, done_o at t=145
- Layer 6: op0 -> (0,128) zeta 1; op127 -> (127,255) zeta 1; 128 writes; done_o once.
- rnd_valid_i toggling 1,0 every cycle on layer 2: 128 issues over 255 clks; wr_en_o pattern equals issue_o delayed 16; address sequence identical to the no-gap run.
- Zeroize at t=50 of a layer-3 pass: next clk all outputs 0, IDLE, no done_o. A fresh start then completes normally.
- start_i with layer_i=7 -> err_o pulse, busy_o stays 0. start_i during ISSUE -> ignored, latched L unchanged.
- Async reset_n low mid-DRAIN -> outputs 0 immediately. After release, no stray wr_en_o.

Source files
------------

// File: rtl/ntt_defines_pkg.sv
// Shared NTT definitions: latencies, layer count and scheduler state type.
package ntt_defines_pkg;

  localparam int unsigned MLKEM_MASKED_GS_BF_LATENCY = 15;
  localparam int unsigned MLKEM_INTT_NUM_LAYERS      = 7;

  typedef enum logic [1:0] {
    BF_IDLE  = 2'd0,
    BF_ISSUE = 2'd1,
    BF_DRAIN = 2'd2,
    BF_DONE  = 2'd3
  } ntt_bf_sched_state_e;

endpackage

// File: rtl/ntt_mlkem_bf_wb_delay.sv
// Valid + payload shift register tracking in-flight butterfly ops to write-back.
module ntt_mlkem_bf_wb_delay #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         zeroize,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) dat_q[k] <= '0;
    end else if (zeroize) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) dat_q[k] <= '0;
    end else begin
      vld_q    <= {vld_q[DEPTH-2:0], valid_i};
      dat_q[0] <= data_i;
      for (int unsigned k = 1; k < DEPTH; k++) dat_q[k] <= dat_q[k-1];
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/ntt_mlkem_masked_intt_bf_sched.sv
// Sequences one ML-KEM INTT layer through the fixed-latency masked GS butterfly.
module ntt_mlkem_masked_intt_bf_sched
  import ntt_defines_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BF_LAT = MLKEM_MASKED_GS_BF_LATENCY
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              zeroize,
  input  logic              start_i,
  input  logic [2:0]        layer_i,
  input  logic              rnd_valid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              issue_o,
  output logic [ADDR_W-1:0] rd_u_addr_o,
  output logic [ADDR_W-1:0] rd_v_addr_o,
  output logic [6:0]        zeta_idx_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_u_addr_o,
  output logic [ADDR_W-1:0] wr_v_addr_o
);

  localparam int unsigned DLY   = RD_LAT + BF_LAT;
  localparam int unsigned CNT_W = $clog2(DLY);
  localparam logic [2:0]  LAST_LAYER = 3'(MLKEM_INTT_NUM_LAYERS - 1);

  ntt_bf_sched_state_e state_q;
  logic [2:0]          layer_q;
  logic [6:0]          op_q;
  logic [CNT_W-1:0]    drain_q;

  logic [ADDR_W-1:0] len, j, u, v;
  logic [6:0]        g;
  logic [2*ADDR_W-1:0] wb_data;

  assign issue_o = (state_q == BF_ISSUE) && rnd_valid_i && !zeroize;
  assign err_o   = (state_q == BF_IDLE) && start_i && (layer_i > LAST_LAYER) && !zeroize;
  assign busy_o  = (state_q != BF_IDLE);
  assign done_o  = (state_q == BF_DONE);

  // Group/offset decomposition of op index: u = g*2*len + j, v = u + len.
  always_comb begin
    len = ADDR_W'(2) << layer_q;
    j   = ADDR_W'(op_q) & (len - ADDR_W'(1));
    g   = op_q >> ({1'b0, layer_q} + 4'd1);
    u   = (ADDR_W'(g) << ({1'b0, layer_q} + 4'd2)) | j;
    v   = u + len;
  end

  assign rd_u_addr_o = issue_o ? u : '0;
  assign rd_v_addr_o = issue_o ? v : '0;
  assign zeta_idx_o  = issue_o ? ((7'h7f >> layer_q) - g) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BF_IDLE;
      layer_q <= '0;
      op_q    <= '0;
      drain_q <= '0;
    end else if (zeroize) begin
      state_q <= BF_IDLE;
      layer_q <= '0;
      op_q    <= '0;
      drain_q <= '0;
    end else begin
      case (state_q)
        BF_IDLE: begin
          if (start_i && (layer_i <= LAST_LAYER)) begin
            layer_q <= layer_i;
            op_q    <= '0;
            state_q <= BF_ISSUE;
          end
        end
        BF_ISSUE: begin
          if (issue_o) begin
            op_q <= op_q + 7'd1;
            if (op_q == 7'd127) begin
              drain_q <= '0;
              state_q <= BF_DRAIN;
            end
          end
        end
        BF_DRAIN: begin
          drain_q <= drain_q + 1'b1;
          if (drain_q == CNT_W'(DLY - 1)) state_q <= BF_DONE;
        end
        default: state_q <= BF_IDLE;
      endcase
    end
  end

  assign wb_data = {rd_u_addr_o, rd_v_addr_o};

  ntt_mlkem_bf_wb_delay #(
    .DEPTH (DLY),
    .W     (2*ADDR_W)
  ) u_wb_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .zeroize (zeroize),
    .valid_i (issue_o),
    .data_i  (wb_data),
    .valid_o (wr_en_o),
    .data_o  ({wr_u_addr_o, wr_v_addr_o})
  );

endmodule

// File: tb/tb_ntt_mlkem_masked_intt_bf_sched.sv
// Randomized self-checking bench for the masked INTT butterfly scheduler.
module tb_ntt_mlkem_masked_intt_bf_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       zeroize = 1'b0;
  logic       start_i = 1'b0;
  logic [2:0] layer_i = '0;
  logic       rnd_valid_i = 1'b0;
  logic       busy_o, done_o, err_o, issue_o, wr_en_o;
  logic [7:0] rd_u_addr_o, rd_v_addr_o, wr_u_addr_o, wr_v_addr_o;
  logic [6:0] zeta_idx_o;

  int errors = 0;
  int checks = 0;
  int exp_u[$], exp_v[$], exp_z[$];

  wire [43:0] all_out = {busy_o, done_o, err_o, issue_o, rd_u_addr_o, rd_v_addr_o,
                         zeta_idx_o, wr_en_o, wr_u_addr_o, wr_v_addr_o};

  ntt_mlkem_masked_intt_bf_sched #(
    .ADDR_W (8),
    .RD_LAT (1),
    .BF_LAT (15)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .zeroize     (zeroize),
    .start_i     (start_i),
    .layer_i     (layer_i),
    .rnd_valid_i (rnd_valid_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .issue_o     (issue_o),
    .rd_u_addr_o (rd_u_addr_o),
    .rd_v_addr_o (rd_v_addr_o),
    .zeta_idx_o  (zeta_idx_o),
    .wr_en_o     (wr_en_o),
    .wr_u_addr_o (wr_u_addr_o),
    .wr_v_addr_o (wr_v_addr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Reference butterfly order: groups of 2*len coefficients, pairs (j, j+len).
  task automatic build_ref(input int L);
    int len;
    exp_u.delete(); exp_v.delete(); exp_z.delete();
    len = 2 << L;
    for (int grp = 0; grp < 256 / (2 * len); grp++)
      for (int jj = 0; jj < len; jj++) begin
        exp_u.push_back(grp * 2 * len + jj);
        exp_v.push_back(grp * 2 * len + jj + len);
        exp_z.push_back((128 >> L) - 1 - grp);
      end
  endtask

  // mode: 0 always valid, 1 alternate 1/0, 2 random. abort_kind: 1 zeroize, 2 async reset.
  task automatic run_pass(input int L, input int mode, input int abort_cyc, input int abort_kind,
                          input int poke_start, output int first_iss, output int last_iss,
                          output int done_t, output int n_iss);
    int pend_t[$], pend_u[$], pend_v[$];
    int n_wr;
    logic exp_wr;
    first_iss = -1; last_iss = -1; done_t = -1; n_iss = 0; n_wr = 0;
    build_ref(L);
    @(negedge clk);
    start_i = 1'b1; layer_i = 3'(L); rnd_valid_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL start_idle: err=%b busy=%b, required 0 0", err_o, busy_o);
    for (int cyc = 1; cyc <= 700; cyc++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (poke_start != 0 && cyc == 5) begin
        start_i = 1'b1;
        layer_i = 3'((L + 3) % 7);
      end
      case (mode)
        0: rnd_valid_i = 1'b1;
        1: rnd_valid_i = cyc[0];
        default: rnd_valid_i = ($urandom_range(0, 3) != 0);
      endcase
      if (cyc == abort_cyc && abort_kind == 1) begin
        zeroize = 1'b1;
        return;
      end
      #1;
      exp_wr = (pend_t.size() > 0) && (pend_t[0] + 16 == cyc);
      checks++;
      if (wr_en_o !== exp_wr) begin
        errors++;
        $display("FAIL wr_en L=%0d cyc=%0d: got %b, required %b", L, cyc, wr_en_o, exp_wr);
      end
      if (exp_wr) begin
        checks++;
        if (wr_u_addr_o !== 8'(pend_u[0]) || wr_v_addr_o !== 8'(pend_v[0])) begin
          errors++;
          $display("FAIL wr_addr L=%0d cyc=%0d: got (%0d,%0d), required (%0d,%0d)",
                   L, cyc, wr_u_addr_o, wr_v_addr_o, pend_u[0], pend_v[0]);
        end
        void'(pend_t.pop_front()); void'(pend_u.pop_front()); void'(pend_v.pop_front());
        n_wr++;
      end
      if (issue_o === 1'b1) begin
        checks++;
        if (n_iss >= 128) begin
          errors++;
          $display("FAIL extra_issue L=%0d cyc=%0d: got issue #%0d, required at most 128", L, cyc, n_iss + 1);
        end else if (rd_u_addr_o !== 8'(exp_u[n_iss]) || rd_v_addr_o !== 8'(exp_v[n_iss]) ||
                     zeta_idx_o !== 7'(exp_z[n_iss])) begin
          errors++;
          $display("FAIL rd_addr L=%0d op=%0d: got (%0d,%0d) z%0d, required (%0d,%0d) z%0d",
                   L, n_iss, rd_u_addr_o, rd_v_addr_o, zeta_idx_o, exp_u[n_iss], exp_v[n_iss], exp_z[n_iss]);
        end
        if (n_iss < 128) begin
          pend_t.push_back(cyc); pend_u.push_back(exp_u[n_iss]); pend_v.push_back(exp_v[n_iss]);
        end
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc;
        n_iss++;
      end
      if (done_o === 1'b1) begin
        done_t = cyc;
        checks++;
        if (n_iss != 128 || n_wr != 128 || pend_t.size() != 0) begin
          errors++;
          $display("FAIL done_counts L=%0d: got issues=%0d writes=%0d, required 128 128", L, n_iss, n_wr);
        end
        break;
      end
      if (cyc == abort_cyc && abort_kind == 2) begin
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
          errors++;
          $display("FAIL reset_async_out: got %h, required 0", all_out);
        end
        return;
      end
      if (cyc == 700) begin
        errors++;
        $display("FAIL pass_timeout L=%0d: no done_o within 700 cycles", L);
      end
    end
    @(negedge clk);
    start_i = 1'b0; rnd_valid_i = 1'b0;
    #1;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL post_done: done=%b busy=%b, required 0 0", done_o, busy_o);
    end
  endtask

  task automatic quiet_window(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rnd_valid_i = ($urandom_range(0, 1) != 0);
      #1;
      checks++;
      if (wr_en_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || issue_o !== 1'b0) begin
        errors++;
        $display("FAIL %s: wr_en=%b done=%b busy=%b issue=%b, required all 0",
                 name, wr_en_o, done_o, busy_o, issue_o);
      end
    end
  endtask

  task automatic expect_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rnd_valid_i = 1'b1; start_i = 1'b1; layer_i = 3'd2;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
    start_i = 1'b0; rnd_valid_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_release: got %h, required 0", all_out);
    end
  endtask

  task automatic test_layer0();
    int fi, li, dt, ni;
    run_pass(0, 0, 0, 0, 0, fi, li, dt, ni);
    expect_int("l0_first_issue", fi, 1);
    expect_int("l0_last_issue", li, 128);
    expect_int("l0_done_time", dt, 145);
    expect_int("l0_issue_count", ni, 128);
  endtask

  task automatic test_layer6();
    int fi, li, dt, ni;
    run_pass(6, 0, 0, 0, 0, fi, li, dt, ni);
    expect_int("l6_done_time", dt, 145);
    expect_int("l6_issue_count", ni, 128);
  endtask

  task automatic test_gaps();
    int fi, li, dt, ni;
    run_pass(2, 1, 0, 0, 0, fi, li, dt, ni);
    expect_int("gap_last_issue", li, 255);
    expect_int("gap_done_time", dt, 272);
  endtask

  task automatic test_random_ignore_start();
    int fi, li, dt, ni;
    for (int p = 0; p < 3; p++) begin
      int L = int'($urandom_range(0, 6));
      run_pass(L, 2, 0, 0, 1, fi, li, dt, ni);
      expect_int("rand_issue_count", ni, 128);
      expect_int("rand_done_after_last", dt, li + 17);
    end
  endtask

  task automatic test_error();
    @(negedge clk);
    start_i = 1'b1; layer_i = 3'd7;
    #1;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: err=%b busy=%b, required 1 0", err_o, busy_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL err_after: err=%b busy=%b, required 0 0", err_o, busy_o);
    end
  endtask

  task automatic test_zeroize();
    int fi, li, dt, ni;
    run_pass(3, 0, 50, 1, 0, fi, li, dt, ni);
    @(negedge clk);
    zeroize = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL zeroize_out: got %h, required 0", all_out);
    end
    quiet_window("zeroize_quiet", 40);
    run_pass(3, 0, 0, 0, 0, fi, li, dt, ni);
    expect_int("zeroize_restart_done", dt, 145);
  endtask

  task automatic test_reset_drain();
    int fi, li, dt, ni;
    run_pass(1, 0, 135, 2, 0, fi, li, dt, ni);
    @(negedge clk);
    reset_n = 1'b1;
    quiet_window("reset_quiet", 40);
    run_pass(5, 0, 0, 0, 0, fi, li, dt, ni);
    expect_int("reset_restart_done", dt, 145);
  endtask

  initial begin
    test_reset();
    test_layer0();
    test_layer6();
    test_gaps();
    test_random_ignore_start();
    test_error();
    test_zeroize();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
